uart_tx_ctrl: RTL and testbench

UART transmit controller: accepts one parallel word per handshake, latches it with the frame configuration, and sequences the TX frame as start, data bits LSB first, optional parity, then stop. It drives the latched word and parity configuration into the combinational TX parity calculator, reads back its parity bit, and drives the serial line directly. It sits between the system-side TX data source and the UART TX pin, in the UART TX clock domain.

---
 rtl/uart_tx_ctrl.sv | 96 +++++++++
 tb/tb_uart_tx_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: latches one word per handshake and serialises it as
// start, LSB-first data, optional parity (from an external calculator), stop.
module uart_tx_ctrl #(
   parameter int unsigned data_width = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Data_Valid,
   input  logic [data_width-1:0] P_DATA,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  PARITY_BIT,
   output logic [data_width-1:0] P_DATA_LAT,
   output logic                  PAR_EN_LAT,
   output logic                  PAR_TYP_LAT,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int unsigned CntW = $clog2(data_width);
   localparam logic [CntW-1:0] LastBit = CntW'(data_width - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [data_width-1:0] data_lat_q, data_lat_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         data_lat_q <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         data_lat_q <= data_lat_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      data_lat_d = data_lat_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      unique case (state_q)
         StIdle: begin
            // Latches only move on acceptance so mid-frame input changes are harmless.
            if (Data_Valid) begin
               data_lat_d = P_DATA;
               par_en_d   = PAR_EN;
               par_typ_d  = PAR_TYP;
               bit_cnt_d  = '0;
               state_d    = StStart;
            end
         end
         StStart: state_d = StData;
         StData: begin
            if (bit_cnt_q == LastBit) begin
               bit_cnt_d = '0;
               state_d   = par_en_q ? StParity : StStop;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         StParity: state_d = StStop;
         StStop:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      TX_OUT = 1'b1;
      Busy   = 1'b1;
      unique case (state_q)
         StIdle:   Busy   = 1'b0;
         StStart:  TX_OUT = 1'b0;
         StData:   TX_OUT = data_lat_q[bit_cnt_q];
         StParity: TX_OUT = PARITY_BIT;
         StStop:   TX_OUT = 1'b1;
         default:  Busy   = 1'b0;
      endcase
   end

   assign P_DATA_LAT  = data_lat_q;
   assign PAR_EN_LAT  = par_en_q;
   assign PAR_TYP_LAT = par_typ_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: directed frames push hand-computed serial bits
// and busy-run lengths; a negedge monitor pops and compares.
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       dv = 1'b0;
   logic [7:0] pdata = 8'h00;
   logic       pen = 1'b0;
   logic       ptyp = 1'b0;
   logic       par_bit;
   logic [7:0] pdata_lat;
   logic       pen_lat;
   logic       ptyp_lat;
   logic       tx_out;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic bit_q[$];
   int   len_q[$];
   int   run = 0;

   always #5 clk = ~clk;

   // Parity calculator model: even -> XOR of bits, odd -> inverted, 0 when disabled.
   assign par_bit = pen_lat & (ptyp_lat ? ~(^pdata_lat) : (^pdata_lat));

   uart_tx_ctrl #(.data_width(8)) dut (
      .CLK        (clk),
      .RST        (rst),
      .Data_Valid (dv),
      .P_DATA     (pdata),
      .PAR_EN     (pen),
      .PAR_TYP    (ptyp),
      .PARITY_BIT (par_bit),
      .P_DATA_LAT (pdata_lat),
      .PAR_EN_LAT (pen_lat),
      .PAR_TYP_LAT(ptyp_lat),
      .TX_OUT     (tx_out),
      .Busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame bits are given first-bit-at-MSB over len bits.
   task automatic expect_frame(input logic [11:0] bits, input int len);
      for (int i = len - 1; i >= 0; i--) bit_q.push_back(bits[i]);
      len_q.push_back(len);
   endtask

   // Monitor: compare every busy cycle's TX_OUT and each busy-run length.
   always @(negedge clk) begin
      if (busy === 1'b1) begin
         run++;
         if (bit_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_busy: got tx=%0b expected no frame", tx_out);
         end else begin
            chk("tx_bit", {31'd0, tx_out}, {31'd0, bit_q.pop_front()});
         end
      end else begin
         if (rst) chk("idle_tx", {31'd0, tx_out}, 32'd1);
         if (run > 0) begin
            if (len_q.size() == 0) chk("busy_len_unexpected", run, 0);
            else chk("busy_len", run, len_q.pop_front());
            run = 0;
         end
      end
   end

   task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
      @(negedge clk);
      pdata = d;
      pen   = pe;
      ptyp  = pt;
      dv    = 1'b1;
      @(posedge clk);
      #1 dv = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (busy === 1'b1) chk("wait_idle_timeout", 1, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int gap;
      int n;
      // Reset held with a pending request that must not be taken.
      dv    = 1'b1;
      pdata = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx", {31'd0, tx_out}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_plat", {24'd0, pdata_lat}, 32'h00);
      chk("rst_pen", {31'd0, pen_lat}, 32'd0);
      dv  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // No parity, 0xA5.
      expect_frame(12'b0101001011, 10);
      accept(8'hA5, 1'b0, 1'b0);
      chk("lat_a5", {24'd0, pdata_lat}, 32'hA5);
      wait_idle();

      // Even parity, 0xA5.
      expect_frame(12'b01010010101, 11);
      accept(8'hA5, 1'b1, 1'b0);
      wait_idle();

      // Odd parity, 0x01, inputs disturbed mid-frame.
      expect_frame(12'b01000000001, 11);
      accept(8'h01, 1'b1, 1'b1);
      pdata = 8'hFF;
      pen   = 1'b0;
      repeat (3) @(negedge clk);
      chk("lat_hold_data", {24'd0, pdata_lat}, 32'h01);
      chk("lat_hold_pen", {31'd0, pen_lat}, 32'd1);
      wait_idle();

      // Back-to-back with Data_Valid held high: 0x3C then 0xC3.
      expect_frame(12'b0001111001, 10);
      expect_frame(12'b0110000111, 10);
      accept(8'h3C, 1'b0, 1'b0);
      dv    = 1'b1;
      pdata = 8'hC3;
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      gap = 0;
      while (busy === 1'b0 && gap < 30) begin
         @(negedge clk);
         gap++;
      end
      chk("b2b_gap", gap, 1);
      repeat (3) @(negedge clk);
      dv = 1'b0;
      wait_idle();

      // Reset during DATA bit 3 of 0x5A; only the partial frame is expected.
      expect_frame(12'b00101, 5);
      accept(8'h5A, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_tx", {31'd0, tx_out}, 32'd1);
      chk("midrst_plat", {24'd0, pdata_lat}, 32'h00);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Fresh frame after reset: 0x96 odd parity.
      expect_frame(12'b00110100111, 11);
      accept(8'h96, 1'b1, 1'b1);
      wait_idle();

      chk("bits_left", bit_q.size(), 0);
      chk("lens_left", len_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
